// File: rtl/systolic_result_collector.sv
// Systolic result collector.
// Captures one result word per PE, each on the rising edge of that PE's
// finish flag. Once every PE has reported, the words are streamed out in
// row-major order over a valid/ready handshake.
//
// Ports:
//   i_clock       - clock; all state updates on the rising edge
//   i_reset       - asynchronous active-high reset
//   i_valid       - array enable; PE outputs are sampled only while high
//   i_finish      - per-PE finish flags; bit k = PE (row*DIMENSION + col)
//   i_c           - flattened PE results; slice [k*C_BITS +: C_BITS] = PE k
//   i_ready       - downstream consumer ready
//   o_data        - current result word (0 when not draining)
//   o_data_valid  - o_data is valid (high throughout DRAIN)
//   o_busy        - high in COLLECT or DRAIN
//   o_done        - one-cycle pulse after the last word has transferred
//   o_overrun     - sticky error: duplicate capture, or capture during DRAIN
module systolic_result_collector #(
  parameter int DIMENSION = 4,
  parameter int C_BITS    = 16
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_valid,
  input  logic [DIMENSION*DIMENSION-1:0]        i_finish,
  input  logic [DIMENSION*DIMENSION*C_BITS-1:0] i_c,
  input  logic                                i_ready,
  output logic [C_BITS-1:0]                   o_data,
  output logic                                o_data_valid,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_overrun
);

  localparam int NPE = DIMENSION * DIMENSION;
  localparam int IW  = (NPE > 1) ? $clog2(NPE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [NPE-1:0]    prev_q;
  logic              seed_q;
  logic [NPE-1:0]    flags_q, flags_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic [C_BITS-1:0] buf_q [NPE];

  logic [NPE-1:0]    event_w;
  logic [NPE-1:0]    store_w;
  logic [NPE-1:0]    flags_set_w;

  // seed_q stays low until the first enabled cycle after reset, so that the
  // history register holds a real sample before any edge is recognised; a
  // finish level already high at reset release must first drop to 0.
  assign event_w = {NPE{i_valid & seed_q}} & i_finish & ~prev_q;

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    store_w     = '0;
    flags_set_w = flags_q;

    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        store_w     = event_w & ~flags_q;
        flags_set_w = flags_q | store_w;
        if (|(event_w & flags_q)) overrun_d = 1'b1;
        if (&flags_set_w) begin
          state_d = S_DRAIN;
          idx_d   = '0;
          flags_d = '0;
        end else begin
          flags_d = flags_set_w;
          if (state_q == S_IDLE && (|event_w)) state_d = S_COLLECT;
        end
      end
      S_DRAIN: begin
        if (|event_w) overrun_d = 1'b1;
        if (i_ready) begin
          if (idx_q == IW'(NPE - 1)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      prev_q    <= '0;
      seed_q    <= 1'b0;
      flags_q   <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      if (i_valid) begin
        prev_q <= i_finish;
        seed_q <= 1'b1;
      end
    end
  end

  // Result buffer carries no reset; its contents are only read in DRAIN,
  // which is reachable only after every entry has been written.
  always_ff @(posedge i_clock) begin
    for (int unsigned k = 0; k < NPE; k++) begin
      if (store_w[k]) buf_q[k] <= i_c[k*C_BITS +: C_BITS];
    end
  end

  assign o_data_valid = (state_q == S_DRAIN);
  assign o_data       = (state_q == S_DRAIN) ? buf_q[idx_q] : '0;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed testbench for systolic_result_collector (DIMENSION=4, C_BITS=16).
module tb_systolic_result_collector;

  localparam int D   = 4;
  localparam int NPE = D * D;
  localparam int CB  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              vld;
  logic              rdy;
  logic [NPE-1:0]    fin;
  logic [NPE*CB-1:0] cin;
  logic [CB-1:0]     o_data;
  logic              o_data_valid;
  logic              o_busy;
  logic              o_done;
  logic              o_overrun;

  int checks = 0;
  int errors = 0;
  logic [CB-1:0] exp_w [NPE];
  int transfers;
  int step;

  always #5 clk = ~clk;

  systolic_result_collector #(
    .DIMENSION (D),
    .C_BITS    (CB)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_valid      (vld),
    .i_finish     (fin),
    .i_c          (cin),
    .i_ready      (rdy),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_overrun    (o_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Load i_c with k*3 and the matching expectations.
  task automatic load_k3();
    for (int k = 0; k < NPE; k++) begin
      cin[k*CB +: CB] = CB'(k * 3);
      exp_w[k]        = CB'(k * 3);
    end
  endtask

  // Drain n words with i_ready=1, checking order; optionally check o_done.
  task automatic drain(input string tag, input int n, input bit full);
    rdy = 1'b1;
    for (int w = 0; w < n; w++) begin
      chk({tag, "_valid"}, 32'(o_data_valid), 32'd1);
      chk({tag, "_data"}, 32'(o_data), 32'(exp_w[w]));
      tick();
    end
    if (full) begin
      chk({tag, "_done"}, 32'(o_done), 32'd1);
      chk({tag, "_valid_end"}, 32'(o_data_valid), 32'd0);
      chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
      tick();
      chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    vld = 1'b0;
    rdy = 1'b0;
    fin = '0;
    cin = '0;
    #2;
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_valid", 32'(o_data_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    vld = 1'b1;
    rdy = 1'b1;

    // Staggered finish wave, i_ready=1.
    load_k3();
    for (int cyc = 0; cyc <= 16; cyc++) begin
      for (int k = 0; k < NPE; k++) fin[k] = (cyc >= 10 + k / D + k % D);
      if (cyc == 12) chk("t1_busy", 32'(o_busy), 32'd1);
      if (cyc == 16) chk("t1_pre_valid", 32'(o_data_valid), 32'd0);
      tick();
    end
    drain("t1", NPE, 1'b1);
    chk("t1_overrun", 32'(o_overrun), 32'd0);

    // Same wave, i_ready toggling 1,0,1,0.
    fin = '0;
    tick();
    for (int cyc = 0; cyc <= 16; cyc++) begin
      for (int k = 0; k < NPE; k++) fin[k] = (cyc >= 10 + k / D + k % D);
      tick();
    end
    transfers = 0;
    step = 0;
    while (transfers < NPE && step < 64) begin
      rdy = (step % 2 == 0);
      chk("t2_valid", 32'(o_data_valid), 32'd1);
      chk("t2_data", 32'(o_data), 32'(exp_w[transfers]));
      if (rdy) transfers++;
      step++;
      tick();
    end
    chk("t2_transfers", 32'(transfers), 32'd16);
    chk("t2_done", 32'(o_done), 32'd1);
    chk("t2_valid_end", 32'(o_data_valid), 32'd0);
    rdy = 1'b1;

    // All finish bits rise together; drain with i_valid=0.
    fin = '0;
    tick();
    for (int k = 0; k < NPE; k++) begin
      cin[k*CB +: CB] = 16'hFF00 + CB'(k);
      exp_w[k]        = 16'hFF00 + CB'(k);
    end
    fin = '1;
    tick();
    vld = 1'b0;
    drain("t3", NPE, 1'b1);
    vld = 1'b1;

    // PE5 reports twice during COLLECT; first value kept.
    fin = '0;
    tick();
    load_k3();
    cin[5*CB +: CB] = 16'd7;
    exp_w[5]        = 16'd7;
    fin[5] = 1'b1;
    tick();
    chk("t4_busy", 32'(o_busy), 32'd1);
    fin[5] = 1'b0;
    tick();
    cin[5*CB +: CB] = 16'd9;
    fin[5] = 1'b1;
    tick();
    chk("t4_overrun_set", 32'(o_overrun), 32'd1);
    chk("t4_still_collect", 32'(o_data_valid), 32'd0);
    fin = '1;
    tick();
    drain("t4", NPE, 1'b1);
    chk("t4_overrun_sticky", 32'(o_overrun), 32'd1);

    // Reset with finish held high: no capture until it drops.
    fin = '1;
    rst = 1'b1;
    tick();
    chk("t5_rst_overrun", 32'(o_overrun), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("t5_no_capture", 32'(o_busy), 32'd0);
    chk("t5_no_valid", 32'(o_data_valid), 32'd0);
    fin = '0;
    tick();
    load_k3();
    fin = '1;
    tick();
    // PE0 pulses during DRAIN: overrun, output unchanged.
    rdy = 1'b1;
    for (int w = 0; w < NPE; w++) begin
      if (w == 0) fin[0] = 1'b0;
      if (w == 1) fin[0] = 1'b1;
      chk("t5_valid", 32'(o_data_valid), 32'd1);
      chk("t5_data", 32'(o_data), 32'(exp_w[w]));
      tick();
    end
    chk("t5_done", 32'(o_done), 32'd1);
    chk("t5_overrun", 32'(o_overrun), 32'd1);
    tick();

    // Reset after 8 words, then a fresh collection.
    fin = '0;
    tick();
    fin = '1;
    tick();
    drain("t6a", 8, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(o_data_valid), 32'd0);
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    chk("t6_rst_data", 32'(o_data), 32'd0);
    fin = '0;
    tick();
    rst = 1'b0;
    chk("t6_no_done", 32'(o_done), 32'd0);
    tick();
    chk("t6_no_done2", 32'(o_done), 32'd0);
    for (int k = 0; k < NPE; k++) begin
      cin[k*CB +: CB] = CB'(100 + k);
      exp_w[k]        = CB'(100 + k);
    end
    fin = '1;
    tick();
    drain("t6b", NPE, 1'b1);
    chk("t6_overrun", 32'(o_overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_result_collector.md
SYSTOLIC_RESULT_COLLECTOR -- requirements
Module: systolic_result_collector

Interface
REQ-001 Parameter DIMENSION, default 4, sets the array side; the block serves DIMENSION*DIMENSION PEs.
REQ-002 Parameter C_BITS, default 16, sets the width of each PE result word.
REQ-003 i_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset; it is the only reset.
REQ-005 i_valid  input  1  array enable; PE outputs are sampled only in cycles where it is 1.
REQ-006 i_finish  input  DIMENSION*DIMENSION  per-PE finish flags; bit k belongs to PE k = row*DIMENSION + col.
REQ-007 i_c  input  DIMENSION*DIMENSION*C_BITS  flattened PE results; slice [k*C_BITS +: C_BITS] belongs to PE k.
REQ-008 i_ready  input  1  downstream consumer ready.
REQ-009 o_data  output  C_BITS  current result word.
REQ-010 o_data_valid  output  1  o_data is valid.
REQ-011 o_busy  output  1  high in COLLECT or DRAIN.
REQ-012 o_done  output  1  one-cycle pulse after the last word is transferred.
REQ-013 o_overrun  output  1  sticky error flag.

Function
REQ-014 Each PE bit is edge-detected: a capture event for PE k occurs when i_valid=1, i_finish[k]=1, and the registered previous i_finish[k]=0.
REQ-015 The previous-finish register updates only when i_valid=1.
REQ-016 The block has three states: IDLE, COLLECT, DRAIN.
REQ-017 In IDLE or COLLECT, a capture event for PE k whose captured flag is clear stores i_c slice k into buffer entry k and sets flag k in the same cycle.
REQ-018 Any capture event in IDLE moves the FSM to COLLECT.
REQ-019 Any number of simultaneous capture events in one cycle are all stored.
REQ-020 A capture event for PE k whose flag is already set keeps the first value and sets o_overrun.
REQ-021 When all flags are set (including flags set this cycle), the next state is DRAIN, the read index is 0, and the flags clear.
REQ-022 In DRAIN, o_data_valid=1 and o_data = buffer[index], in row-major order, index 0 through DIMENSION*DIMENSION-1.
REQ-023 Handshake: a word transfers when o_data_valid=1 and i_ready=1, which increments the index.
REQ-024 o_data is held stable while i_ready=0.
REQ-025 A transfer at index DIMENSION*DIMENSION-1 returns the FSM to IDLE and pulses o_done for exactly the next cycle.
REQ-026 In DRAIN, capture events are not stored, and each one sets o_overrun.
REQ-027 Edge-detect history keeps updating in every state, so a finish level held across DRAIN produces no later event.
REQ-028 Latency from the last capture to the first o_data_valid is 1 cycle; with i_ready held at 1, draining takes DIMENSION*DIMENSION cycles.
REQ-029 The index width is $clog2(DIMENSION*DIMENSION).
REQ-030 The index never wraps within a drain.
REQ-031 i_valid=0 freezes capture only; draining continues regardless of i_valid.
REQ-032 o_overrun clears only on reset.

Reset
REQ-033 While i_reset=1, the FSM is in IDLE and the index, flags, finish history, o_data_valid, o_done, o_busy and o_overrun are 0.
REQ-034 While i_reset=1, o_data=0 and buffer contents are don't-care.
REQ-035 Reset asserted mid-COLLECT or mid-DRAIN discards partial results immediately, with no o_done.
REQ-036 After reset deassertion, a finish level already high is not a capture event until it first drops to 0.

Verification
REQ-037 DIMENSION=4: PE k finish rises at cycle 10+(k/4)+(k%4) with i_c[k]=k*3, i_ready=1 -> 16 words 0,3,...,45 in order, first valid 1 cycle after the PE15 capture, o_done 1 cycle after word 45, o_overrun=0.
REQ-038 Same stimulus with i_ready toggling 1,0,1,0 -> same 16 words, each held stable while i_ready=0, exactly 16 transfers.
REQ-039 All 16 finish bits rise in one cycle with i_c[k]=16'hFF00+k -> DRAIN next cycle, output 16'hFF00..16'hFF0F.
REQ-040 PE5 finish pulses twice during COLLECT (values 7, then 9) -> word 5 = 7, o_overrun=1.
REQ-041 PE0 finish pulses during DRAIN -> o_overrun=1, drain output unchanged.
REQ-042 i_reset pulsed after 8 words are transferred -> o_data_valid=0 immediately; a fresh full collection then outputs from index 0.
